instruction_cache_controller: RTL and testbench

//  Direct-mapped instruction cache (8 sets x 128-bit block) and controller between CPU fetch stage and instruction_memory.

---
 rtl/instruction_cache_controller.sv | 128 ++++++++++++
 tb/tb_instruction_cache_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache_controller.sv
// Direct-mapped, read-only instruction cache (8 sets x 16-byte blocks) with a
// fixed-latency block refill from instruction memory.
module instruction_cache_controller #(
    parameter int MEM_LATENCY = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [9:0]   address,
    input  logic         flush,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readinst
);

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t       state_q;
    logic [7:0]   valid_q;
    logic [2:0]   tag_q [8];
    logic [127:0] data_q [8];
    logic [3:0]   cnt_q;
    logic [5:0]   missAddr_q;
    logic [127:0] fill_q;
    logic [31:0]  instr_q;
    logic         memRead_q;
    logic [5:0]   memAddress_q;

    logic [2:0]   addrTag;
    logic [2:0]   addrIndex;
    logic [1:0]   addrWord;
    logic         hit;
    logic [127:0] selBlock;
    logic [31:0]  selWord;
    logic         unusedByteOffset;

    assign addrTag   = address[9:7];
    assign addrIndex = address[6:4];
    assign addrWord  = address[3:2];

    // Byte-within-word bits play no part in a word fetch.
    assign unusedByteOffset = ^address[1:0];

    assign hit = read && (state_q == IDLE) && valid_q[addrIndex]
                 && (tag_q[addrIndex] == addrTag);

    assign selBlock = data_q[addrIndex];

    always_comb begin
        selWord = selBlock[31:0];
        case (addrWord)
            2'd0: selWord = selBlock[31:0];
            2'd1: selWord = selBlock[63:32];
            2'd2: selWord = selBlock[95:64];
            2'd3: selWord = selBlock[127:96];
            default: selWord = selBlock[31:0];
        endcase
    end

    // A hit is forwarded straight from the array so a hit costs no cycle.
    assign instruction = hit ? selWord : instr_q;
    assign busywait    = reset && ((state_q == IDLE) ? (read && !hit) : 1'b1);
    assign mem_read    = memRead_q;
    assign mem_address = memAddress_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            cnt_q        <= '0;
            missAddr_q   <= '0;
            instr_q      <= '0;
            memRead_q    <= 1'b0;
            memAddress_q <= '0;
        end else begin
            if (hit) begin
                instr_q <= selWord;
            end
            if (flush) begin
                valid_q      <= '0;
                state_q      <= IDLE;
                cnt_q        <= '0;
                memRead_q    <= 1'b0;
                memAddress_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (read && !hit) begin
                            missAddr_q   <= address[9:4];
                            cnt_q        <= '0;
                            memRead_q    <= 1'b1;
                            memAddress_q <= address[9:4];
                            state_q      <= MEM_READ;
                        end
                    end
                    MEM_READ: begin
                        if (cnt_q == LAST_CNT) begin
                            fill_q       <= mem_readinst;
                            memRead_q    <= 1'b0;
                            memAddress_q <= '0;
                            state_q      <= UPDATE;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    UPDATE: begin
                        valid_q[missAddr_q[2:0]] <= 1'b1;
                        state_q                  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Tag and data storage are never cleared; only the valid bits gate their use.
    always_ff @(posedge clock) begin
        if (reset && !flush && (state_q == UPDATE)) begin
            data_q[missAddr_q[2:0]] <= fill_q;
            tag_q[missAddr_q[2:0]]  <= missAddr_q[5:3];
        end
    end

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Scoreboard bench for instruction_cache_controller: a block-level cache model
// predicts each fetch's word and stall length; a negedge monitor checks them.
module tb_instruction_cache_controller;

    localparam int LAT = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         read = 1'b0;
    logic [9:0]   address = '0;
    logic         flush = 1'b0;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst = '0;

    instruction_cache_controller #(.MEM_LATENCY(LAT)) dut (
        .clock(clock),
        .reset(reset),
        .read(read),
        .address(address),
        .flush(flush),
        .instruction(instruction),
        .busywait(busywait),
        .mem_read(mem_read),
        .mem_address(mem_address),
        .mem_readinst(mem_readinst)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        int          stall;
        logic [5:0]  blk;
    } exp_t;

    logic [7:0] memBytes [1024];
    exp_t       expQ [$];
    int         checks = 0;
    int         failures = 0;
    int         responses = 0;
    int         stallCnt = 0;
    int         memCycles = 0;
    int         addrErr = 0;
    int         memCnt = 0;
    bit         refValid [8];
    logic [5:0] refBlk [8];

    function automatic logic [31:0] memWord(input logic [9:0] a);
        int base;
        base = int'({a[9:2], 2'b00});
        return {memBytes[base + 3], memBytes[base + 2], memBytes[base + 1], memBytes[base]};
    endfunction

    function automatic logic [127:0] memBlock(input logic [5:0] b);
        logic [127:0] blk;
        for (int k = 0; k < 16; k++) begin
            blk[8 * k +: 8] = memBytes[int'(b) * 16 + k];
        end
        return blk;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Memory returns the real block only once mem_read has been high LAT cycles.
    always @(negedge clock) begin
        if (mem_read === 1'b1) memCnt++;
        else memCnt = 0;
        if (memCnt >= LAT) mem_readinst = memBlock(mem_address);
        else mem_readinst = {$urandom, $urandom, $urandom, $urandom};
    end

    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            if (mem_read === 1'b1) begin
                memCycles++;
                if (mem_address !== expQ[0].blk) addrErr++;
            end else if (mem_address !== 6'd0) begin
                addrErr++;
            end
            if (read && busywait === 1'b0) begin
                checkOutput("instruction", instruction, expQ[0].instr);
                checkOutput("stallCycles", 32'(stallCnt), 32'(expQ[0].stall));
                checkOutput("memReadCycles", 32'(memCycles), (expQ[0].stall == 0) ? 32'd0 : 32'(LAT));
                checkOutput("memAddressErrors", 32'(addrErr), 32'd0);
                void'(expQ.pop_front());
                stallCnt  = 0;
                memCycles = 0;
                addrErr   = 0;
                responses++;
            end else begin
                stallCnt++;
            end
        end
    end

    task automatic applyStimulus(input logic [9:0] addr);
        exp_t e;
        logic [2:0] idx;
        int start;
        bit got;
        idx     = addr[6:4];
        e.blk   = addr[9:4];
        e.instr = memWord(addr);
        e.stall = (refValid[idx] && refBlk[idx] == addr[9:4]) ? 0 : LAT + 2;
        refValid[idx] = 1'b1;
        refBlk[idx]   = addr[9:4];
        start = responses;
        expQ.push_back(e);
        read    = 1'b1;
        address = addr;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            if (responses > start) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL fetchTimeout addr=%0h actual=no response required=response", addr);
            expQ.delete();
            stallCnt  = 0;
            memCycles = 0;
            addrErr   = 0;
        end
        #1;
    endtask

    task automatic doFlush();
        read  = 1'b0;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 8; i++) refValid[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] a;
        logic [2:0] t;
        bit done;
        for (int i = 0; i < 1024; i++) begin
            memBytes[i] = (i >= 16 && i < 32) ? 8'(i - 16) : 8'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            refValid[i] = 1'b0;
            refBlk[i]   = '0;
        end

        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("resetBusywait", 32'(busywait), 32'd0);
        checkOutput("resetMemRead", 32'(mem_read), 32'd0);
        checkOutput("resetMemAddress", 32'(mem_address), 32'd0);
        checkOutput("resetInstruction", instruction, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        applyStimulus(10'h000);
        applyStimulus(10'h014);
        applyStimulus(10'h018);
        doFlush();
        applyStimulus(10'h018);
        applyStimulus(10'h094);
        applyStimulus(10'h014);

        read    = 1'b1;
        address = 10'h234;
        repeat (3) @(posedge clock);
        #1;
        read = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (busywait === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("dropReadRelease", 32'(done), 32'd1);
        refValid[3] = 1'b1;
        refBlk[3]   = 6'h23;
        @(posedge clock);
        #1;
        applyStimulus(10'h238);

        doFlush();
        read    = 1'b1;
        address = 10'h014;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("busywaitInReset", 32'(busywait), 32'd0);
        checkOutput("memReadBeforeReset", 32'(mem_read), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        read  = 1'b0;
        for (int i = 0; i < 8; i++) refValid[i] = 1'b0;
        @(negedge clock);
        checkOutput("memReadAfterReset", 32'(mem_read), 32'd0);
        checkOutput("memAddressAfterReset", 32'(mem_address), 32'd0);
        @(posedge clock);
        #1;
        applyStimulus(10'h014);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) doFlush();
            t = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            a = {t, 7'($urandom)};
            applyStimulus(a);
        end

        read = 1'b0;
        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
